decode_stage_ctrl: RTL and testbench

Registered MIPS decode stage for the pipelined core: decodes the fetched word, produces the control bundle and holds it in the ID/EX pipeline register. Adds valid/ready handshakes, load-use hazard stalls with configurable load latency, flush handling and sticky halt sequencing. Sits between fetch and execute. Reuses the cpu_types_pkg opcode, funct and aluop encodings.

---
 rtl/decode_stage_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_decode_stage_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_ctrl
// Purpose  : Registered MIPS decode stage. Decodes the fetched word into the
//            execute control bundle and holds it in the ID/EX register.
//            Provides valid/ready handshaking toward fetch and execute,
//            load-use stalls against a LOAD_LAT-deep load scoreboard, flush
//            handling and sticky HALT sequencing.
// Ports    : CLK, nRST (async, active low)
//            if_valid/if_instr/if_pc -> id_ready   : fetch side handshake
//            flush                                 : taken branch/jump in EX
//            ex_ready -> ex_valid + ex_* fields    : ID/EX register contents
//            halt                                  : sticky, HALT accepted by EX
// Config   : `define BRANCH_DELAY_SLOT_EN makes the instruction in decode when
//            flush rises a delay slot; the following decode-slot word is
//            killed instead.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_ctrl #(
   parameter int PC_W     = 32,
   parameter int LOAD_LAT = 1,
   parameter int REG_AW   = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [PC_W-1:0]   if_pc,
   output logic              id_ready,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [PC_W-1:0]   ex_pc,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_wsel,
   output logic [4:0]        ex_shamt,
   output logic [31:0]       ex_imm32,
   output logic [25:0]       ex_imm26,
   output logic [3:0]        ex_alu_ctr,
   output logic [1:0]        ex_alu_src,
   output logic              ex_reg_wr,
   output logic              ex_mem_rd,
   output logic              ex_mem_wr,
   output logic [1:0]        ex_mem_to_reg,
   output logic              ex_jump,
   output logic              ex_branch,
   output logic              ex_branch_neq,
   output logic              ex_jr,
   output logic              halt
);

   // Opcode encodings (cpu_types_pkg compatible)
   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_J     = 6'h02;
   localparam logic [5:0] c_OP_JAL   = 6'h03;
   localparam logic [5:0] c_OP_BEQ   = 6'h04;
   localparam logic [5:0] c_OP_BNE   = 6'h05;
   localparam logic [5:0] c_OP_ADDI  = 6'h08;
   localparam logic [5:0] c_OP_ADDIU = 6'h09;
   localparam logic [5:0] c_OP_SLTI  = 6'h0A;
   localparam logic [5:0] c_OP_SLTIU = 6'h0B;
   localparam logic [5:0] c_OP_ANDI  = 6'h0C;
   localparam logic [5:0] c_OP_ORI   = 6'h0D;
   localparam logic [5:0] c_OP_XORI  = 6'h0E;
   localparam logic [5:0] c_OP_LUI   = 6'h0F;
   localparam logic [5:0] c_OP_LW    = 6'h23;
   localparam logic [5:0] c_OP_SW    = 6'h2B;
   localparam logic [5:0] c_OP_HALT  = 6'h3F;

   // Function encodings
   localparam logic [5:0] c_FN_SLL  = 6'h00;
   localparam logic [5:0] c_FN_SRL  = 6'h02;
   localparam logic [5:0] c_FN_JR   = 6'h08;
   localparam logic [5:0] c_FN_ADD  = 6'h20;
   localparam logic [5:0] c_FN_ADDU = 6'h21;
   localparam logic [5:0] c_FN_SUB  = 6'h22;
   localparam logic [5:0] c_FN_SUBU = 6'h23;
   localparam logic [5:0] c_FN_AND  = 6'h24;
   localparam logic [5:0] c_FN_OR   = 6'h25;
   localparam logic [5:0] c_FN_XOR  = 6'h26;
   localparam logic [5:0] c_FN_NOR  = 6'h27;
   localparam logic [5:0] c_FN_SLT  = 6'h2A;
   localparam logic [5:0] c_FN_SLTU = 6'h2B;

   // aluop_t encodings
   localparam logic [3:0] c_ALU_SLL  = 4'b0000;
   localparam logic [3:0] c_ALU_SRL  = 4'b0001;
   localparam logic [3:0] c_ALU_ADD  = 4'b0010;
   localparam logic [3:0] c_ALU_SUB  = 4'b0011;
   localparam logic [3:0] c_ALU_AND  = 4'b0100;
   localparam logic [3:0] c_ALU_OR   = 4'b0101;
   localparam logic [3:0] c_ALU_XOR  = 4'b0110;
   localparam logic [3:0] c_ALU_NOR  = 4'b0111;
   localparam logic [3:0] c_ALU_SLT  = 4'b1010;
   localparam logic [3:0] c_ALU_SLTU = 4'b1011;

   // ID/EX register contents; an all-zero value is a bubble.
   typedef struct packed {
      logic              valid;
      logic [PC_W-1:0]   pc;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] wsel;
      logic [4:0]        shamt;
      logic [31:0]       imm32;
      logic [25:0]       imm26;
      logic [3:0]        alu_ctr;
      logic [1:0]        alu_src;
      logic              reg_wr;
      logic              mem_rd;
      logic              mem_wr;
      logic [1:0]        mem_to_reg;
      logic              jump;
      logic              branch;
      logic              branch_neq;
      logic              jr;
      logic              is_halt;
   } idex_t;

   idex_t                          r_idex;
   idex_t                          w_dec;
   logic [LOAD_LAT-1:0]            r_sb_v;
   logic [LOAD_LAT-1:0][REG_AW-1:0] r_sb_reg;
   logic [LOAD_LAT-1:0]            w_sb_v_nxt;
   logic [LOAD_LAT-1:0][REG_AW-1:0] w_sb_reg_nxt;
   logic                           w_sb_in_v;
   logic                           r_halted;
   logic                           r_halt;
   logic                           w_adv;
   logic                           w_kill;
   logic                           w_stall;
   logic                           w_hit;
   logic                           w_issue;
   logic                           w_use_rs;
   logic                           w_use_rt;
   logic [5:0]                     w_op;
   logic [5:0]                     w_fn;

   assign w_op = if_instr[31:26];
   assign w_fn = if_instr[5:0];

   // ------------------------------------------------------------------------
   // Instruction decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_dec         = '0;
      w_dec.valid   = 1'b1;
      w_dec.pc      = if_pc;
      w_dec.rs      = REG_AW'(if_instr[25:21]);
      w_dec.rt      = REG_AW'(if_instr[20:16]);
      w_dec.wsel    = REG_AW'(if_instr[20:16]);
      w_dec.shamt   = if_instr[10:6];
      w_dec.imm32   = {{16{if_instr[15]}}, if_instr[15:0]};
      w_dec.imm26   = if_instr[25:0];
      w_dec.alu_ctr = c_ALU_ADD;
      case (w_op)
         c_OP_RTYPE: begin
            w_dec.wsel   = REG_AW'(if_instr[15:11]);
            w_dec.reg_wr = 1'b1;
            case (w_fn)
               c_FN_SLL:            begin w_dec.alu_ctr = c_ALU_SLL; w_dec.alu_src = 2'd1; end
               c_FN_SRL:            begin w_dec.alu_ctr = c_ALU_SRL; w_dec.alu_src = 2'd1; end
               c_FN_JR:             begin w_dec.jr = 1'b1; w_dec.reg_wr = 1'b0; end
               c_FN_ADD, c_FN_ADDU: w_dec.alu_ctr = c_ALU_ADD;
               c_FN_SUB, c_FN_SUBU: w_dec.alu_ctr = c_ALU_SUB;
               c_FN_AND:            w_dec.alu_ctr = c_ALU_AND;
               c_FN_OR:             w_dec.alu_ctr = c_ALU_OR;
               c_FN_XOR:            w_dec.alu_ctr = c_ALU_XOR;
               c_FN_NOR:            w_dec.alu_ctr = c_ALU_NOR;
               c_FN_SLT:            w_dec.alu_ctr = c_ALU_SLT;
               c_FN_SLTU:           w_dec.alu_ctr = c_ALU_SLTU;
               default:             w_dec.reg_wr  = 1'b0;
            endcase
         end
         c_OP_J:   w_dec.jump = 1'b1;
         c_OP_JAL: begin
            w_dec.jump       = 1'b1;
            w_dec.wsel       = REG_AW'(5'd31);
            w_dec.reg_wr     = 1'b1;
            w_dec.mem_to_reg = 2'd2;
         end
         c_OP_BEQ: begin w_dec.branch = 1'b1; w_dec.alu_ctr = c_ALU_SUB; end
         c_OP_BNE: begin
            w_dec.branch     = 1'b1;
            w_dec.branch_neq = 1'b1;
            w_dec.alu_ctr    = c_ALU_SUB;
         end
         c_OP_ADDI, c_OP_ADDIU: begin w_dec.alu_src = 2'd1; w_dec.reg_wr = 1'b1; end
         c_OP_SLTI: begin
            w_dec.alu_ctr = c_ALU_SLT;  w_dec.alu_src = 2'd1; w_dec.reg_wr = 1'b1;
         end
         c_OP_SLTIU: begin
            w_dec.alu_ctr = c_ALU_SLTU; w_dec.alu_src = 2'd1; w_dec.reg_wr = 1'b1;
         end
         c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
            w_dec.imm32   = {16'h0, if_instr[15:0]};
            w_dec.alu_src = 2'd1;
            w_dec.reg_wr  = 1'b1;
            w_dec.alu_ctr = (w_op == c_OP_ANDI) ? c_ALU_AND :
                            (w_op == c_OP_ORI)  ? c_ALU_OR  : c_ALU_XOR;
         end
         c_OP_LUI: begin
            w_dec.imm32   = {if_instr[15:0], 16'h0};
            w_dec.alu_src = 2'd2;
            w_dec.reg_wr  = 1'b1;
         end
         c_OP_LW: begin
            w_dec.alu_src    = 2'd1;
            w_dec.mem_rd     = 1'b1;
            w_dec.reg_wr     = 1'b1;
            w_dec.mem_to_reg = 2'd1;
         end
         c_OP_SW:   begin w_dec.alu_src = 2'd1; w_dec.mem_wr = 1'b1; end
         c_OP_HALT: w_dec.is_halt = 1'b1;
         default:   ;
      endcase
      // $0 is hard-wired, so a write to it is dropped at decode; this also
      // makes the all-zero word (sll $0) a harmless valid instruction.
      if (w_dec.wsel == '0) w_dec.reg_wr = 1'b0;
   end

   // ------------------------------------------------------------------------
   // Hazard detection against in-flight loads
   // ------------------------------------------------------------------------
   assign w_use_rs = !(w_op == c_OP_J || w_op == c_OP_JAL ||
                       w_op == c_OP_LUI || w_op == c_OP_HALT);
   assign w_use_rt = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) ||
                     (w_op == c_OP_BNE)   || (w_op == c_OP_SW);

   always_comb begin
      w_hit = 1'b0;
      for (int i = 0; i < LOAD_LAT; i++) begin
         if (r_sb_v[i] && (r_sb_reg[i] != '0)) begin
            if (w_use_rs && (w_dec.rs == r_sb_reg[i])) w_hit = 1'b1;
            if (w_use_rt && (w_dec.rt == r_sb_reg[i])) w_hit = 1'b1;
         end
      end
   end

   assign w_stall = if_valid & w_hit;

   // ------------------------------------------------------------------------
   // Flush / kill
   // ------------------------------------------------------------------------
`ifdef BRANCH_DELAY_SLOT_EN
   // The word in decode when flush rises is the delay slot and proceeds; the
   // pending bit kills the next word fetch presents.
   logic r_flush_pend;
   assign w_kill = r_flush_pend;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                       r_flush_pend <= 1'b0;
      else if (flush)                  r_flush_pend <= 1'b1;
      else if (r_flush_pend && if_valid) r_flush_pend <= 1'b0;
   end
`else
   assign w_kill = flush;
`endif

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   assign w_adv    = ex_ready | ~r_idex.valid;
   // A kill must let fetch discard its word immediately, even over a stall.
   assign id_ready = w_kill | (w_adv & ~w_stall & ~r_halted);
   assign w_issue  = if_valid & id_ready & ~w_kill;

   // ------------------------------------------------------------------------
   // Scoreboard shift: new entry enters at index 0
   // ------------------------------------------------------------------------
   assign w_sb_in_v = w_issue & (w_op == c_OP_LW) & (w_dec.wsel != '0);

   generate
      if (LOAD_LAT > 1) begin : g_sb_deep
         assign w_sb_v_nxt   = {r_sb_v[LOAD_LAT-2:0], w_sb_in_v};
         assign w_sb_reg_nxt = {r_sb_reg[LOAD_LAT-2:0], w_dec.wsel};
      end else begin : g_sb_single
         assign w_sb_v_nxt   = w_sb_in_v;
         assign w_sb_reg_nxt = w_dec.wsel;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // ID/EX register, scoreboard and halt state
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_idex   <= '0;
         r_sb_v   <= '0;
         r_sb_reg <= '0;
         r_halted <= 1'b0;
         r_halt   <= 1'b0;
      end else begin
         if (w_adv) begin
            r_idex   <= w_issue ? w_dec : '0;
            r_sb_v   <= w_sb_v_nxt;
            r_sb_reg <= w_sb_reg_nxt;
         end
         if (w_issue && w_dec.is_halt) r_halted <= 1'b1;
         if (r_idex.valid && ex_ready && r_idex.is_halt) r_halt <= 1'b1;
      end
   end

   // halt is visible in the very cycle EX accepts HALT, then held sticky.
   assign halt = r_halt | (r_idex.valid & ex_ready & r_idex.is_halt);

   assign ex_valid      = r_idex.valid;
   assign ex_pc         = r_idex.pc;
   assign ex_rs         = r_idex.rs;
   assign ex_rt         = r_idex.rt;
   assign ex_wsel       = r_idex.wsel;
   assign ex_shamt      = r_idex.shamt;
   assign ex_imm32      = r_idex.imm32;
   assign ex_imm26      = r_idex.imm26;
   assign ex_alu_ctr    = r_idex.alu_ctr;
   assign ex_alu_src    = r_idex.alu_src;
   assign ex_reg_wr     = r_idex.reg_wr;
   assign ex_mem_rd     = r_idex.mem_rd;
   assign ex_mem_wr     = r_idex.mem_wr;
   assign ex_mem_to_reg = r_idex.mem_to_reg;
   assign ex_jump       = r_idex.jump;
   assign ex_branch     = r_idex.branch;
   assign ex_branch_neq = r_idex.branch_neq;
   assign ex_jr         = r_idex.jr;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_ctrl
// Purpose  : Directed self-checking bench for decode_stage_ctrl (default
//            build, LOAD_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_ctrl;

   localparam int PC_W     = 32;
   localparam int LOAD_LAT = 1;
   localparam int REG_AW   = 5;

   localparam logic [3:0]  c_ALU_ADD = 4'b0010;
   localparam logic [31:0] c_HALT    = 32'hFC000000;

   logic              CLK      = 1'b0;
   logic              nRST     = 1'b1;
   logic              if_valid = 1'b0;
   logic [31:0]       if_instr = 32'h0;
   logic [PC_W-1:0]   if_pc    = '0;
   logic              flush    = 1'b0;
   logic              ex_ready = 1'b1;
   logic              id_ready;
   logic              ex_valid;
   logic [PC_W-1:0]   ex_pc;
   logic [REG_AW-1:0] ex_rs, ex_rt, ex_wsel;
   logic [4:0]        ex_shamt;
   logic [31:0]       ex_imm32;
   logic [25:0]       ex_imm26;
   logic [3:0]        ex_alu_ctr;
   logic [1:0]        ex_alu_src;
   logic              ex_reg_wr, ex_mem_rd, ex_mem_wr;
   logic [1:0]        ex_mem_to_reg;
   logic              ex_jump, ex_branch, ex_branch_neq, ex_jr;
   logic              halt;

   int checks = 0;
   int errors = 0;

   decode_stage_ctrl #(.PC_W(PC_W), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW)) dut (
      .CLK(CLK), .nRST(nRST), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_wsel(ex_wsel), .ex_shamt(ex_shamt), .ex_imm32(ex_imm32),
      .ex_imm26(ex_imm26), .ex_alu_ctr(ex_alu_ctr), .ex_alu_src(ex_alu_src),
      .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_jump(ex_jump), .ex_branch(ex_branch),
      .ex_branch_neq(ex_branch_neq), .ex_jr(ex_jr), .halt(halt)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      if_valid = v;
      if_instr = ins;
      if_pc    = pc;
   endtask

   task automatic test_reset();
      #1 nRST = 1'b0;
      #2;
      checks++;
      if ({ex_valid, halt, id_ready, ex_wsel, ex_imm32, ex_pc, ex_reg_wr} !==
          {1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got v=%0b h=%0b rdy=%0b wsel=%0d imm=%h pc=%h rw=%0b want 0 0 1 0 0 0 0",
                  ex_valid, halt, id_ready, ex_wsel, ex_imm32, ex_pc, ex_reg_wr);
      end
      #9 nRST = 1'b1;
      step();
      checks++;
      if (ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_bubble got ex_valid=%0b want 0", ex_valid);
      end
   endtask

   task automatic test_addiu();
      drive(1'b1, 32'h24010005, 32'h100);
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL addiu_ready got %0b want 1", id_ready);
      end
      step();
      checks++;
      if ({ex_valid, ex_wsel, ex_imm32, ex_alu_src, ex_reg_wr, ex_alu_ctr, ex_mem_rd} !==
          {1'b1, 5'd1, 32'd5, 2'd1, 1'b1, c_ALU_ADD, 1'b0}) begin
         errors++;
         $display("FAIL addiu_fields got v=%0b wsel=%0d imm=%h src=%0d rw=%0b alu=%h mrd=%0b want 1 1 5 1 1 2 0",
                  ex_valid, ex_wsel, ex_imm32, ex_alu_src, ex_reg_wr, ex_alu_ctr, ex_mem_rd);
      end
      checks++;
      if (ex_pc !== 32'h100) begin
         errors++;
         $display("FAIL addiu_pc got %h want 00000100", ex_pc);
      end
      drive(1'b0, 32'h0, 32'h0);
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins  [6];
      logic [44:0] want [6];
      logic [44:0] got;
      // {valid, wsel, imm32, alu_src, reg_wr, mem_to_reg, jump, mem_wr}
      ins[0] = 32'h3C061234; want[0] = {1'b1, 5'd6,  32'h12340000, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0};
      ins[1] = 32'h2407FFFF; want[1] = {1'b1, 5'd7,  32'hFFFFFFFF, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0};
      ins[2] = 32'h3423FFFF; want[2] = {1'b1, 5'd3,  32'h0000FFFF, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0};
      ins[3] = 32'h0C000010; want[3] = {1'b1, 5'd31, 32'h00000010, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0};
      ins[4] = 32'h00000000; want[4] = {1'b1, 5'd0,  32'h00000000, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0};
      ins[5] = 32'hAC220004; want[5] = {1'b1, 5'd2,  32'h00000004, 2'd1, 1'b0, 2'd0, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, ins[k], 32'h200 + 32'(4 * k));
         step();
         got = {ex_valid, ex_wsel, ex_imm32, ex_alu_src, ex_reg_wr, ex_mem_to_reg, ex_jump, ex_mem_wr};
         checks++;
         if (got !== want[k]) begin
            errors++;
            $display("FAIL b2b_%0d instr=%h got %h want %h", k, ins[k], got, want[k]);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 32'h0, 32'h0);
      nRST = 1'b0;
      #2;
      checks++;
      if ({ex_valid, ex_mem_wr, ex_imm32, ex_alu_src, halt, id_ready} !==
          {1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset got v=%0b mw=%0b imm=%h src=%0d h=%0b rdy=%0b want 0 0 0 0 0 1",
                  ex_valid, ex_mem_wr, ex_imm32, ex_alu_src, halt, id_ready);
      end
      nRST = 1'b1;
   endtask

   task automatic test_load_use();
      // dependent ADDU after LW $2: one stall cycle, one bubble
      drive(1'b1, 32'h8C220000, 32'h300);
      step();
      checks++;
      if ({ex_valid, ex_mem_rd, ex_wsel, ex_mem_to_reg} !== {1'b1, 1'b1, 5'd2, 2'd1}) begin
         errors++;
         $display("FAIL lw_fields got v=%0b mrd=%0b wsel=%0d m2r=%0d want 1 1 2 1",
                  ex_valid, ex_mem_rd, ex_wsel, ex_mem_to_reg);
      end
      drive(1'b1, 32'h00421821, 32'h304);
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_use_stall got id_ready=%0b want 0", id_ready);
      end
      step();
      checks++;
      if ({ex_valid, id_ready} !== 2'b01) begin
         errors++;
         $display("FAIL load_use_bubble got v=%0b rdy=%0b want 0 1", ex_valid, id_ready);
      end
      step();
      checks++;
      if ({ex_valid, ex_wsel, ex_rs, ex_alu_ctr} !== {1'b1, 5'd3, 5'd2, c_ALU_ADD}) begin
         errors++;
         $display("FAIL load_use_issue got v=%0b wsel=%0d rs=%0d alu=%h want 1 3 2 2",
                  ex_valid, ex_wsel, ex_rs, ex_alu_ctr);
      end
      // independent ADDU after LW $2: no stall
      drive(1'b1, 32'h8C220000, 32'h308);
      step();
      drive(1'b1, 32'h00211821, 32'h30C);
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL lw_indep got id_ready=%0b want 1", id_ready);
      end
      step();
      // LW to $0 never stalls a consumer of $0
      drive(1'b1, 32'h8C200000, 32'h310);
      step();
      drive(1'b1, 32'h00001821, 32'h314);
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL lw_zero got id_ready=%0b want 1", id_ready);
      end
      step();
      checks++;
      if ({ex_valid, ex_wsel} !== {1'b1, 5'd3}) begin
         errors++;
         $display("FAIL lw_zero_issue got v=%0b wsel=%0d want 1 3", ex_valid, ex_wsel);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 32'h24040007, 32'h400);
      ex_ready = 1'b1;
      step();
      ex_ready = 1'b0;
      drive(1'b1, 32'h24050009, 32'h404);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (id_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready_%0d got %0b want 0", k, id_ready);
         end
         step();
         checks++;
         if ({ex_valid, ex_wsel, ex_imm32, ex_pc} !== {1'b1, 5'd4, 32'd7, 32'h400}) begin
            errors++;
            $display("FAIL hold_%0d got v=%0b wsel=%0d imm=%h pc=%h want 1 4 7 400",
                     k, ex_valid, ex_wsel, ex_imm32, ex_pc);
         end
      end
      ex_ready = 1'b1;
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready got %0b want 1", id_ready);
      end
      step();
      checks++;
      if ({ex_valid, ex_wsel, ex_imm32} !== {1'b1, 5'd5, 32'd9}) begin
         errors++;
         $display("FAIL release_load got v=%0b wsel=%0d imm=%h want 1 5 9", ex_valid, ex_wsel, ex_imm32);
      end
      drive(1'b0, 32'h0, 32'h0);
      step();
   endtask

   task automatic test_flush();
      drive(1'b1, 32'h3423FFFF, 32'h500);
      flush = 1'b1;
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready got %0b want 1", id_ready);
      end
      step();
      checks++;
      if ({ex_valid, ex_imm32} !== {1'b0, 32'd0}) begin
         errors++;
         $display("FAIL flush_kill got v=%0b imm=%h want 0 00000000", ex_valid, ex_imm32);
      end
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      step();
      // flush overrides a load-use stall
      drive(1'b1, 32'h8C220000, 32'h510);
      step();
      drive(1'b1, 32'h00421821, 32'h514);
      flush = 1'b1;
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_over_stall got id_ready=%0b want 1", id_ready);
      end
      step();
      checks++;
      if (ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_stall_bubble got ex_valid=%0b want 0", ex_valid);
      end
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      step();
   endtask

   task automatic test_halt();
      // a flushed HALT never halts
      drive(1'b1, c_HALT, 32'h600);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      step();
      checks++;
      if ({halt, id_ready, ex_valid} !== 3'b010) begin
         errors++;
         $display("FAIL halt_flushed got h=%0b rdy=%0b v=%0b want 0 1 0", halt, id_ready, ex_valid);
      end
      // HALT issued while EX is not ready: halt waits for acceptance
      ex_ready = 1'b0;
      drive(1'b1, c_HALT, 32'h604);
      step();
      drive(1'b1, 32'h24040007, 32'h608);
      #1;
      checks++;
      if ({ex_valid, halt, id_ready} !== 3'b100) begin
         errors++;
         $display("FAIL halt_pending got v=%0b h=%0b rdy=%0b want 1 0 0", ex_valid, halt, id_ready);
      end
      ex_ready = 1'b1;
      #1;
      checks++;
      if (halt !== 1'b1) begin
         errors++;
         $display("FAIL halt_accept got %0b want 1", halt);
      end
      step();
      checks++;
      if ({ex_valid, halt, id_ready} !== 3'b010) begin
         errors++;
         $display("FAIL halt_sticky got v=%0b h=%0b rdy=%0b want 0 1 0", ex_valid, halt, id_ready);
      end
      ex_ready = 1'b0;
      step();
      step();
      step();
      checks++;
      if ({halt, id_ready, ex_valid} !== 3'b100) begin
         errors++;
         $display("FAIL halt_hold got h=%0b rdy=%0b v=%0b want 1 0 0", halt, id_ready, ex_valid);
      end
      // reset in the halted state restores normal operation
      nRST = 1'b0;
      #2;
      checks++;
      if ({halt, ex_valid, id_ready} !== 3'b001) begin
         errors++;
         $display("FAIL halt_reset got h=%0b v=%0b rdy=%0b want 0 0 1", halt, ex_valid, id_ready);
      end
      nRST     = 1'b1;
      ex_ready = 1'b1;
      step();
      checks++;
      if ({ex_valid, ex_wsel, halt} !== {1'b1, 5'd4, 1'b0}) begin
         errors++;
         $display("FAIL post_halt_issue got v=%0b wsel=%0d h=%0b want 1 4 0", ex_valid, ex_wsel, halt);
      end
      drive(1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      test_reset();
      test_addiu();
      test_back_to_back();
      test_async_reset();
      step();
      test_load_use();
      test_backpressure();
      test_flush();
      test_halt();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
